// File: rtl/wb_master_port_if.sv
// Request/response and Wishbone bus bundle for wb_master_port.
// Signal suffixes are relative to the master (the port block itself).
interface wb_master_port_if #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32
);
    localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

    // Local initiator request channel
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [WB_ADDR_WIDTH-1:0] req_addr_i;
    logic                     req_we_i;
    logic [WB_DATA_WIDTH-1:0] req_wdata_i;
    logic [SEL_W-1:0]         req_sel_i;

    // Response channel back to the initiator
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [WB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                     rsp_err_o;

    // Wishbone classic bus
    logic                     wb_cyc_o;
    logic                     wb_stb_o;
    logic                     wb_we_o;
    logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
    logic [WB_DATA_WIDTH-1:0] wb_wdata_o;
    logic [SEL_W-1:0]         wb_sel_o;
    logic [WB_DATA_WIDTH-1:0] wb_rdata_i;
    logic                     wb_ack_i;
    logic                     wb_err_i;

    // The port block
    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_wdata_o, wb_sel_o,
        input  wb_rdata_i, wb_ack_i, wb_err_i
    );

    // The environment: initiator plus Wishbone slave
    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_wdata_o, wb_sel_o,
        output wb_rdata_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic master: one request -> one bus cycle
// -> one response. Optional bus-cycle abort timer enabled by defining
// WB_MASTER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module wb_master_port #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             wb_clk_i,
    input  logic             rst_ni,
    wb_master_port_if.master bus
);
    localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

    // Elaboration-time parameter sanity
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end
    if ((WB_DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("WB_DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                   state_q;
    logic                     cyc_q;
    logic                     we_q;
    logic [WB_ADDR_WIDTH-1:0] addr_q;
    logic [WB_DATA_WIDTH-1:0] wdata_q;
    logic [SEL_W-1:0]         sel_q;
    logic                     rsp_valid_q;
    logic                     rsp_err_q;
    logic [WB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                     expire;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Current BUS cycle is the last one allowed
    assign expire = (state_q == ST_BUS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts BUS cycles; cleared when the response is consumed
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == ST_BUS) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if ((state_q == ST_RESP) && bus.rsp_ready_i) begin
            cnt_q <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Request -> bus cycle -> response sequencing with registered outputs
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q  <= bus.req_addr_i;
                        we_q    <= bus.req_we_i;
                        wdata_q <= bus.req_wdata_i;
                        sel_q   <= bus.req_sel_i;
                        cyc_q   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // err beats ack; ack/err beat an expiry on the same edge
                    if (bus.wb_err_i || (expire && !bus.wb_ack_i)) begin
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_RESP;
                    end else if (bus.wb_ack_i) begin
                        cyc_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : bus.wb_rdata_i;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // cyc and stb share one register so they always move together
    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_addr_o   = addr_q;
    assign bus.wb_wdata_o  = wdata_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench for wb_master_port: directed plan items plus random
// transactions checked against a transaction-level expectation.
module tb_wb_master_port;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_master_port_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

    wb_master_port #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i(clk),
        .rst_ni  (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_we_i    = 1'b0;
        bus.req_wdata_i = '0;
        bus.req_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wb_rdata_i  = '0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;
    endtask

    // One full transaction. kind: 0=ack, 1=err, 2=ack+err together.
    // d = cycles of stb before the slave answers; wt = response backpressure cycles.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input int d, input int kind, input logic [31:0] rdata,
                           input int wt);
        logic        exp_err;
        logic [31:0] exp_rdata;
        exp_err   = (kind != 0);
        exp_rdata = (exp_err || we) ? 32'h0 : rdata;

        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_ready got=%b exp=1", tag, bus.req_ready_o);
        end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_we_i    = we;
        bus.req_wdata_i = wdata;
        bus.req_sel_i   = sel;
        next_cycle();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;
        bus.req_we_i    = ~we;
        bus.req_wdata_i = $urandom;
        bus.req_sel_i   = 4'($urandom);

        for (int k = 0; k <= d; k++) begin
            checks++;
            if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_wdata_o,
                 bus.wb_sel_o, bus.req_ready_o, bus.rsp_valid_o}
                !== {1'b1, 1'b1, we, addr, wdata, sel, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL %s bus_phase[%0d] got cyc=%b stb=%b we=%b a=%h wd=%h sel=%h rdy=%b rv=%b exp we=%b a=%h wd=%h sel=%h",
                         tag, k, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o,
                         bus.wb_wdata_o, bus.wb_sel_o, bus.req_ready_o, bus.rsp_valid_o,
                         we, addr, wdata, sel);
            end
            bus.wb_rdata_i = $urandom;
            if (k == d) begin
                bus.wb_ack_i   = (kind != 1);
                bus.wb_err_i   = (kind != 0);
                bus.wb_rdata_i = rdata;
            end
            next_cycle();
        end
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
        bus.wb_rdata_i = $urandom;

        for (int w = 0; w <= wt; w++) begin
            checks++;
            if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.rsp_valid_o, bus.rsp_err_o,
                 bus.rsp_rdata_o, bus.req_ready_o}
                !== {1'b0, 1'b0, 1'b0, 1'b1, exp_err, exp_rdata, 1'b0}) begin
                failures++;
                $display("FAIL %s resp_phase[%0d] got cyc=%b we=%b rv=%b err=%b rd=%h rdy=%b exp err=%b rd=%h",
                         tag, w, bus.wb_cyc_o, bus.wb_we_o, bus.rsp_valid_o, bus.rsp_err_o,
                         bus.rsp_rdata_o, bus.req_ready_o, exp_err, exp_rdata);
            end
            // Stray requests and bus answers while the response waits must be ignored
            bus.req_valid_i = (w < wt) ? 1'($urandom) : 1'b0;
            bus.wb_ack_i    = 1'($urandom);
            bus.wb_err_i    = 1'($urandom);
            bus.wb_rdata_i  = $urandom;
            bus.rsp_ready_i = (w == wt);
            next_cycle();
        end
        clear_inputs();
        checks++;
        if ({bus.rsp_valid_o, bus.wb_cyc_o, bus.req_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL %s after_handshake got rv=%b cyc=%b rdy=%b exp rv=0 cyc=0 rdy=1",
                     tag, bus.rsp_valid_o, bus.wb_cyc_o, bus.req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.rsp_valid_o, bus.rsp_err_o,
             bus.wb_addr_o, bus.wb_wdata_o, bus.wb_sel_o, bus.rsp_rdata_o, bus.req_ready_o}
            !== {5'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got cyc=%b rv=%b a=%h wd=%h sel=%h rd=%h rdy=%b exp all zero rdy=1",
                     bus.wb_cyc_o, bus.rsp_valid_o, bus.wb_addr_o, bus.wb_wdata_o,
                     bus.wb_sel_o, bus.rsp_rdata_o, bus.req_ready_o);
        end
        #20;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 4; i++) begin
            bus.wb_ack_i   = 1'b1;
            bus.wb_err_i   = 1'(i);
            bus.wb_rdata_i = $urandom;
            next_cycle();
            checks++;
            if ({bus.wb_cyc_o, bus.rsp_valid_o, bus.req_ready_o} !== 3'b001) begin
                failures++;
                $display("FAIL idle_ack_ignored got cyc=%b rv=%b rdy=%b exp 0 0 1",
                         bus.wb_cyc_o, bus.rsp_valid_o, bus.req_ready_o);
            end
        end
        clear_inputs();
    endtask

    task automatic test_directed();
        run_txn("read_hit", 32'h0001_0004, 1'b0, 32'h0, 4'hF, 2, 0, 32'hDEAD_BEEF, 0);
        run_txn("write", 32'h0001_2000, 1'b1, 32'hCAFE_F00D, 4'h3, 0, 0, 32'h1234_5678, 0);
        run_txn("backpressure", 32'h0000_0040, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0BAD_CAFE, 5);
        run_txn("ack_err_same", 32'h0000_0080, 1'b0, 32'h0, 4'hF, 1, 2, 32'h5555_AAAA, 0);
        run_txn("write_err", 32'h0000_00C0, 1'b1, 32'h1111_2222, 4'hC, 0, 1, 32'h7777_7777, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_txn("back_to_back", $urandom, 1'($urandom), $urandom, 4'($urandom), 0, 0, $urandom, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_txn("random", $urandom, 1'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), $urandom,
                    int'($urandom_range(0, 3)));
    endtask

    task automatic test_timeout();
`ifdef WB_MASTER_TIMEOUT_EN
        int n;
        // Answer on the expiry edge completes normally
        run_txn("ack_at_expiry", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 15, 0, 32'hA5A5_0F0F, 0);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0200;
        bus.req_sel_i   = 4'hF;
        next_cycle();
        bus.req_valid_i = 1'b0;
        n = 0;
        while (bus.wb_stb_o === 1'b1 && n < 40) begin
            n++;
            next_cycle();
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL timeout_len got=%0d exp=16", n);
        end
        bus.wb_ack_i   = 1'b1;
        bus.wb_rdata_i = 32'hFFFF_FFFF;
        next_cycle();
        bus.wb_ack_i   = 1'b0;
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.wb_cyc_o}
            !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_rsp got rv=%b err=%b rd=%h cyc=%b exp rv=1 err=1 rd=0 cyc=0",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.wb_cyc_o);
        end
        bus.rsp_ready_i = 1'b1;
        next_cycle();
        clear_inputs();
        checks++;
        if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_done got rv=%b rdy=%b exp 0 1", bus.rsp_valid_o, bus.req_ready_o);
        end
`else
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0200;
        bus.req_sel_i   = 4'hF;
        next_cycle();
        bus.req_valid_i = 1'b0;
        repeat (1000) next_cycle();
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o} !== 3'b110) begin
            failures++;
            $display("FAIL no_timeout got cyc=%b stb=%b rv=%b exp 1 1 0",
                     bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o);
        end
        bus.wb_ack_i   = 1'b1;
        bus.wb_rdata_i = 32'h600D_DA7A;
        next_cycle();
        bus.wb_ack_i   = 1'b0;
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b0, 32'h600D_DA7A}) begin
            failures++;
            $display("FAIL late_ack_rsp got rv=%b err=%b rd=%h exp rv=1 err=0 rd=600dda7a",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o);
        end
        bus.rsp_ready_i = 1'b1;
        next_cycle();
        clear_inputs();
`endif
    endtask

    task automatic test_reset_mid_cycle();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0300;
        bus.req_we_i    = 1'b1;
        bus.req_wdata_i = 32'h1357_9BDF;
        bus.req_sel_i   = 4'hF;
        next_cycle();
        clear_inputs();
        checks++;
        if (bus.wb_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pre got cyc=%b exp=1", bus.wb_cyc_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.rsp_valid_o, bus.req_ready_o}
            !== {3'b000, 32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_async got cyc=%b stb=%b we=%b a=%h rv=%b rdy=%b exp 0 0 0 0 0 1",
                     bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o,
                     bus.rsp_valid_o, bus.req_ready_o);
        end
        #10;
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        checks++;
        if ({bus.req_ready_o, bus.rsp_valid_o, bus.wb_cyc_o} !== 3'b100) begin
            failures++;
            $display("FAIL mid_reset_after got rdy=%b rv=%b cyc=%b exp 1 0 0",
                     bus.req_ready_o, bus.rsp_valid_o, bus.wb_cyc_o);
        end
        run_txn("after_reset", 32'h0000_0400, 1'b0, 32'h0, 4'hF, 1, 0, 32'hFACE_B00C, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_idle_ignore();
        test_directed();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
